// File: rtl/rx_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo -- receive-side word FIFO for the UART receiver.
//
// A DEPTH-entry (DEPTH = 2**DEPTH_LOG2) circular buffer with show-ahead output.
// The head-of-queue word is always present on dout. Writes are accepted when
// not full. Reads are accepted when not empty. The flags are decoded from the
// stored-word count.
//
// Optional feature macro: RX_FIFO_OVERFLOW_FLAG_EN
//   defined   : overflow is a sticky register. It is set on the edge that
//               follows any cycle with we && full, and it is cleared only by
//               clear or rst_n.
//   undefined : overflow is tied to 0 and no overflow register exists.
//
// Parameters
//   WORD_WIDTH - width of one stored word
//   DEPTH_LOG2 - log2 of the entry count (>= 1)
//
// Ports
//   clk      in   1              rising-edge clock
//   rst_n    in   1              asynchronous active-low reset
//   din      in   WORD_WIDTH     write data
//   we       in   1              write request (one word per cycle)
//   full     out  1              count == DEPTH
//   dout     out  WORD_WIDTH     head-of-queue word (valid when !empty)
//   re       in   1              read request (pops head word)
//   empty    out  1              count == 0
//   count    out  DEPTH_LOG2+1   number of stored words
//   overflow out  1              sticky dropped-write flag
//   clear    in   1              synchronous flush of pointers, count, overflow
// ---------------------------------------------------------------------------
module rx_fifo #(
    parameter int unsigned WORD_WIDTH = 32'd8,
    parameter int unsigned DEPTH_LOG2 = 32'd4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] din,
    input  logic                  we,
    output logic                  full,
    output logic [WORD_WIDTH-1:0] dout,
    input  logic                  re,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  clear
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

    // Count value that means "every entry holds a word" (only the MSB is set).
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1'b1);

    logic [WORD_WIDTH-1:0] mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_en_s;
    logic                  rd_en_s;

    assign full_s  = (count_r == FULL_COUNT);
    assign empty_s = (count_r == {(DEPTH_LOG2 + 1){1'b0}});

    // The full and empty flags sampled this cycle decide acceptance.
    // When the FIFO is full and we && re arrive together, only the read is
    // accepted. When it is empty and we && re arrive together, only the write
    // is accepted.
    assign wr_en_s = we & ~full_s;
    assign rd_en_s = re & ~empty_s;

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy count; clear overrides any same-cycle traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r <= {DEPTH_LOG2{1'b0}};
            count_r  <= {(DEPTH_LOG2 + 1){1'b0}};
        end else begin
            // Pointers wrap naturally from DEPTH-1 to 0 through their width.
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef RX_FIFO_OVERFLOW_FLAG_EN
    logic overflow_r;

    // Sticky record of any write attempted while full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (clear) begin
            overflow_r <= 1'b0;
        end else if (we && full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_fifo -- self-checking bench for rx_fifo (WORD_WIDTH=8, DEPTH=16).
//
// The reference model is a queue of bytes plus a sticky overflow bit. It is
// evaluated directly from the FIFO rules (push when not full, pop when not
// empty, clear/reset empty the queue). Directed vectors come from a table.
// Hand-written sequences cover fill/drain, the simultaneous read/write
// corners, clear and asynchronous reset. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_rx_fifo;

    localparam int WW    = 8;
    localparam int DL    = 4;
    localparam int DEPTH = 16;

`ifdef RX_FIFO_OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WW-1:0] din;
    logic          we;
    logic          full;
    logic [WW-1:0] dout;
    logic          re;
    logic          empty;
    logic [DL:0]   count;
    logic          overflow;
    logic          clear;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    logic       m_ovf;

    always #5 clk = ~clk;

    rx_fifo #(.WORD_WIDTH(WW), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .we(we), .full(full),
        .dout(dout), .re(re), .empty(empty), .count(count),
        .overflow(overflow), .clear(clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge with the given inputs.
    task automatic model_step(input logic w, input logic r, input logic c, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            if (w && was_full && OVF_EN) m_ovf = 1'b1;
            if (r && !was_empty) void'(q.pop_front());
            if (w && !was_full) q.push_back(d);
        end
    endtask

    task automatic check_all();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("count_le_depth", 32'(count <= 5'd16), 32'd1);
        if (q.size() > 0) check("dout", 32'(dout), 32'(q[0]));
    endtask

    // One clock cycle: present inputs, take the edge, advance the model, and
    // check #1 after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [7:0] d);
        we = w; re = r; clear = c; din = d;
        @(posedge clk);
        model_step(w, r, c, d);
        #1;
        we = 1'b0; re = 1'b0; clear = 1'b0;
        check_all();
    endtask

    typedef struct {
        logic       w;
        logic       r;
        logic       c;
        logic [7:0] d;
        int         exp_cnt;
        logic       exp_empty;
        logic [7:0] exp_dout;
        bit         chk_dout;
    } vec_t;

    vec_t vt[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; we = 1'b0; re = 1'b0; clear = 1'b0; din = 8'h00;
        m_ovf = 1'b0;
        q.delete();

        // Reset state, checked while reset is asserted.
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table: basic write/read, then the simultaneous-op case on
        // an empty FIFO.
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'h41, 1, 1'b0, 8'h41, 1'b1};
        vt[1] = '{1'b1, 1'b0, 1'b0, 8'h42, 2, 1'b0, 8'h41, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 8'h42, 1'b1};
        vt[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b0, 8'h33, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h00, 1'b0};
        for (int i = 0; i < 7; i++) begin
            cyc(vt[i].w, vt[i].r, vt[i].c, vt[i].d);
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].exp_cnt));
            check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vt[i].exp_empty));
            if (vt[i].chk_dout) check($sformatf("vec%0d_dout", i), 32'(dout), 32'(vt[i].exp_dout));
        end

        // Fill to full, try a write while full, then drain in order.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        check("full_write_count", 32'(count), 32'd16);
        check("full_write_ovf", 32'(overflow), 32'(OVF_EN));
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(dout), 32'(i));
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check("drain_empty", 32'(empty), 32'd1);

        // Full FIFO with we && re: the read is accepted and the write dropped.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        check("full_wr_rd_count", 32'(count), 32'd15);
        for (int i = 1; i < DEPTH; i++) begin
            check("full_wr_rd_order", 32'(dout), 32'(i));
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end
        check("full_wr_rd_empty", 32'(empty), 32'd1);

        // Clear with we high while 3 words are held and overflow is set.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
        cyc(1'b1, 1'b0, 1'b0, 8'hAA);
        for (int i = 0; i < 13; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
        check("pre_clear_count", 32'(count), 32'd3);
        check("pre_clear_ovf", 32'(overflow), 32'(OVF_EN));
        cyc(1'b1, 1'b0, 1'b1, 8'h99);
        check("clear_count", 32'(count), 32'd0);
        check("clear_empty", 32'(empty), 32'd1);
        check("clear_ovf", 32'(overflow), 32'd0);

        // Asynchronous reset pulsed between edges with 5 words stored.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
        #2;
        rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 8'h7E);
        check("post_rst_dout", 32'(dout), 32'h7E);

        // 40 write/read pairs; the pointers wrap several times.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
        end

        // Randomized traffic in phases biased toward filling, then draining.
        for (int ph = 0; ph < 6; ph++) begin
            int pw;
            int pr;
            pw = (ph % 2 == 0) ? 80 : 25;
            pr = (ph % 2 == 0) ? 25 : 80;
            for (int i = 0; i < 60; i++) begin
                logic w;
                logic r;
                logic c;
                w = ($urandom_range(0, 99) < pw);
                r = ($urandom_range(0, 99) < pr);
                c = ($urandom_range(0, 99) < 2);
                cyc(w, r, c, 8'($urandom_range(0, 255)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
